// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one bit pair per cycle, LSB first, through a single full_adder.
// Latency: done pulse in the DONE cycle, WIDTH+1 cycles of busy per op; one op per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE and never queued. Option: SERIAL_ADDER_OVF_EN.

module full_adder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_x ^ i_y ^ i_carry;
    assign o_carry = (i_x & i_y) | (i_carry & (i_x ^ i_y));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             o_overflow,
`endif
    output logic             o_carry
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_next;

    full_adder u_fa (
        .i_x     (a_sr[0]),
        .i_y     (b_sr[0]),
        .i_carry (carry_q),
        .o_sum   (fa_sum),
        .o_carry (fa_carry)
    );

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign sum_next = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            sum_sr     <= '0;
            cnt        <= '0;
            carry_q    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_sum      <= '0;
            o_carry    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            o_overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        a_sr    <= i_a;
                        b_sr    <= i_b;
                        carry_q <= i_carry;
                        cnt     <= '0;
                        o_busy  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_sr  <= sum_next;
                    carry_q <= fa_carry;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        o_sum      <= sum_next;
                        o_carry    <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry into the MSB vs carry out of it
                        o_overflow <= carry_q ^ fa_carry;
`endif
                        o_done     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         i_carry = 1'b0;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_sum;
    logic         o_carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic         o_overflow;
`endif

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_carry    (i_carry),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_sum      (o_sum),
`ifdef SERIAL_ADDER_OVF_EN
        .o_overflow (o_overflow),
`endif
        .o_carry    (o_carry)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op keeps the block busy for W+1 cycles,
    // the last of which carries the done pulse and the new arithmetic result.
    int         m_left;
    logic [W:0] m_pend;
    logic       m_pend_ovf;
    logic [W-1:0] m_sum;
    logic       m_carry;
    logic       m_ovf;

    function automatic logic signed_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int s;
        s = $signed(a) + $signed(b) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_left     <= 0;
            m_pend     <= '0;
            m_pend_ovf <= 1'b0;
            m_sum      <= '0;
            m_carry    <= 1'b0;
            m_ovf      <= 1'b0;
        end else if (m_left == 0) begin
            if (i_start) begin
                m_left     <= W + 1;
                m_pend     <= {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_carry};
                m_pend_ovf <= signed_ovf(i_a, i_b, i_carry);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_sum   <= m_pend[W-1:0];
                m_carry <= m_pend[W];
                m_ovf   <= m_pend_ovf;
            end
        end
    end

    always @(negedge i_clk) begin
        check("busy", 32'(o_busy), 32'(m_left != 0));
        check("done", 32'(o_done), 32'(m_left == 1));
        check("sum", 32'(o_sum), 32'(m_sum));
        check("carry", 32'(o_carry), 32'(m_carry));
`ifdef SERIAL_ADDER_OVF_EN
        check("overflow", 32'(o_overflow), 32'(m_ovf));
`endif
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic eovf);
        int n;
        @(negedge i_clk);
        i_start = 1'b1; i_a = a; i_b = b; i_carry = c;
        @(negedge i_clk);
        i_start = 1'b0; i_a = W'($urandom); i_b = W'($urandom); i_carry = 1'($urandom);
        n = 1;
        while (!o_done && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        check("op_latency", 32'(n), 32'(W + 1));
        check("op_sum", 32'(o_sum), 32'(es));
        check("op_carry", 32'(o_carry), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check("op_ovf", 32'(o_overflow), 32'(eovf));
`else
        if (eovf === 1'bx) check("op_ovf_arg", 32'(eovf), 32'(0));
`endif
        @(negedge i_clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_sum"}, 32'(o_sum), 32'd0);
        check({tag, "_carry"}, 32'(o_carry), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(o_overflow), 32'd0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check_zero("reset");
        i_rst_n = 1'b1;

        do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Random start density with random operands
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            i_start = ($urandom_range(0, 3) == 0);
            i_a = W'($urandom); i_b = W'($urandom); i_carry = 1'($urandom);
        end
        // Start held high continuously while operands keep changing
        for (int i = 0; i < 80; i++) begin
            @(negedge i_clk);
            i_start = 1'b1;
            i_a = W'($urandom); i_b = W'($urandom); i_carry = 1'($urandom);
        end
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (12) @(negedge i_clk);

        // Reset four cycles into a run, asserted away from any clock edge
        i_start = 1'b1; i_a = 8'hAA; i_b = 8'h55; i_carry = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 check_zero("abort");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (14) @(negedge i_clk);
        do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        do_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
